code_entry: RTL and testbench
=============================

// Module: code_entry
// PURPOSE
//  Keypad front end for the combination-lock controller. Synchronises raw DIGIT/ENTER buttons,
//  collects DIGITS-digit codes, compares them against a programmable stored code, and drives the
//  MATCH level and one-cycle ENTER strobe consumed by the downstream lock FSM.
//  Adds failed-attempt lockout and a PROG mode for changing the stored code.
// PARAMETERS
//  DIGITS        4        digits per code
//  DIGIT_W       4        bits per digit
//  DEFAULT_CODE  16'h1234 stored code after reset (DIGITS*DIGIT_W bits)
//  MAX_FAIL      3        consecutive mismatches before lockout (>=1)
//  LOCK_CYCLES   1000     lockout duration in clk cycles (>=2)
// PORTS
//  clk          in   1                     system clock, rising edge
//  RESET        in   1                     asynchronous, active-high reset
//  DIGIT_IN     in   DIGIT_W               switch value; quasi-static, stable >=3 cycles around press
//  DIGIT_BTN    in   1                     raw digit button (async, active-high)
//  ENTER_BTN    in   1                     raw enter button (async, active-high)
//  PROG         in   1                     level: 1 = next full-length entry overwrites stored code
//  MATCH        out  1                     registered: entry buffer complete and equal to stored code
//  ENTER        out  1                     one-cycle strobe to lock FSM
//  COUNT        out  $clog2(DIGITS+1)      digits currently buffered (saturating)
//  LOCKED_OUT   out  1                     high during lockout
// BEHAVIOUR
//  Reset (async, any cycle incl. mid-entry/lockout): state=IDLE, entry=0, COUNT=0, fail_cnt=0,
//   timer=0, code=DEFAULT_CODE, MATCH=0, ENTER=0, LOCKED_OUT=0, sync flops=0.
//  Buttons: 2-flop synchroniser + rising-edge detect -> dig_p/ent_p, each 1 cycle per press.
//   Press first sampled high at edge k -> pulse seen by FSM at edge k+2 (held button = one pulse).
//  FSM states IDLE, PRESENT, LOCKOUT:
//   IDLE: dig_p -> entry <= {entry[(DIGITS-1)*DIGIT_W-1:0], DIGIT_IN}; COUNT++ saturating at DIGITS;
//     beyond DIGITS the oldest digit shifts out, COUNT stays DIGITS.
//    ent_p & PROG & COUNT==DIGITS -> code <= entry; entry, COUNT cleared; no ENTER; stay IDLE.
//    ent_p & PROG & COUNT<DIGITS  -> entry, COUNT cleared; no ENTER; code unchanged.
//    ent_p & ~PROG -> PRESENT.
//    dig_p and ent_p same cycle: enter processed, digit discarded.
//   PRESENT (exactly 1 cycle): ENTER=1; MATCH holds its value from entry at transition.
//    Exit: entry, COUNT cleared. MATCH -> fail_cnt=0, IDLE. ~MATCH -> fail_cnt++; if it reaches
//    MAX_FAIL -> LOCKOUT (timer=0) else IDLE. Pulses arriving in PRESENT are discarded.
//   LOCKOUT: LOCKED_OUT=1; dig_p/ent_p ignored; timer++ each cycle; at timer==LOCK_CYCLES-1
//    -> IDLE, fail_cnt=0, LOCKED_OUT=0 next cycle. Lockout lasts exactly LOCK_CYCLES cycles.
//  MATCH register: next = (COUNT_next==DIGITS) && (entry_next==code_next); so MATCH is 0 whenever
//   buffer is partial/cleared; valid every cycle (lock FSM samples it with and without ENTER).
//  ENTER, LOCKED_OUT decoded from registered state (glitch-free). No combinational input->output path.
//  PROG changes take effect at the ent_p cycle only; PROG is not synchronised (level switch).
// STRUCTURE
//  lock_pkg: typedef enum logic [1:0] {IDLE, PRESENT, LOCKOUT} entry_state_t; DIGIT_W, DIGITS
//   localparams shared with the lock FSM and display decoders.
//  Sub-module btn_sync_edge (clk, RESET, raw -> pulse), instantiated twice.
//  Top: FSM always_ff + next-state always_comb, entry/code/fail/timer registers, comparator.
// TESTING
//  1 Reset, digits 1,2,3,4, ENTER -> COUNT 1..4, MATCH=1 after 4th digit, ENTER pulse 1 cycle
//    with MATCH=1, then COUNT=0, MATCH=0.
//  2 Digits 1,2,3 then ENTER -> ENTER pulse with MATCH=0, fail_cnt=1; next digits 1,2,3,4 ->
//    MATCH=1 (buffer cleared between).
//  3 Digits 9,1,2,3,4 -> oldest dropped, COUNT=4, MATCH=1; ENTER_BTN held 20 cycles -> one pulse.
//  4 Three wrong codes -> LOCKED_OUT=1 for exactly LOCK_CYCLES cycles; correct code during lockout
//    -> no ENTER, COUNT stays 0; after lockout correct code -> MATCH=1 with ENTER.
//  5 PROG=1, digits 5,6,7,8, ENTER -> no ENTER pulse; PROG=0, 1,2,3,4 -> MATCH=0;
//    5,6,7,8 -> MATCH=1. Reset -> code back to 16'h1234.
//  6 Assert RESET mid-entry (COUNT=2) and mid-lockout -> all outputs 0 asynchronously, IDLE;
//    simultaneous DIGIT/ENTER presses -> ENTER processed, COUNT not incremented.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared definitions for the combination-lock keypad path.
//   DIGITS / DIGIT_W : code geometry, also used by the lock FSM and display decoders
//   entry_state_t    : state encoding of the keypad entry controller
package lock_pkg;

    localparam int DIGITS  = 4;
    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        LOCKOUT = 2'd2
    } entry_state_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Button conditioner: two-flop synchroniser followed by a rising-edge detector.
//   clk   : system clock
//   RESET : asynchronous active-high reset
//   raw   : asynchronous button level
//   pulse : one-cycle pulse per press; a press first sampled at edge k is
//           visible to downstream logic at edge k+2
module btn_sync_edge (
    input  logic clk,
    input  logic RESET,
    input  logic raw,
    output logic pulse
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = raw;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // A held button keeps sync_q and prev_q both high, so only one pulse.
    assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/code_entry.sv
// Keypad front end for the combination lock.
// Collects DIGITS-digit codes, compares them with a programmable stored code,
// and drives MATCH / ENTER to the lock FSM, with failed-attempt lockout.
//   clk, RESET  : system clock, asynchronous active-high reset
//   DIGIT_IN    : quasi-static digit switch value
//   DIGIT_BTN   : raw digit button
//   ENTER_BTN   : raw enter button
//   PROG        : level; next full-length entry overwrites the stored code
//   MATCH       : registered; buffer full and equal to stored code
//   ENTER       : one-cycle strobe to the lock FSM
//   COUNT       : digits currently buffered (saturating)
//   LOCKED_OUT  : high during lockout
//
// state   | meaning
// IDLE    | collecting digits, handling enter / programming
// PRESENT | one cycle: ENTER strobe with MATCH of the submitted entry
// LOCKOUT | too many failures; buttons ignored for LOCK_CYCLES cycles
module code_entry #(
    parameter int                             DIGITS       = lock_pkg::DIGITS,
    parameter int                             DIGIT_W      = lock_pkg::DIGIT_W,
    parameter logic [DIGITS*DIGIT_W-1:0]      DEFAULT_CODE = 16'h1234,
    parameter int                             MAX_FAIL     = 3,
    parameter int                             LOCK_CYCLES  = 1000
) (
    input  logic                              clk,
    input  logic                              RESET,
    input  logic [DIGIT_W-1:0]                DIGIT_IN,
    input  logic                              DIGIT_BTN,
    input  logic                              ENTER_BTN,
    input  logic                              PROG,
    output logic                              MATCH,
    output logic                              ENTER,
    output logic [$clog2(DIGITS+1)-1:0]       COUNT,
    output logic                              LOCKED_OUT
);

    import lock_pkg::*;

    localparam int CW      = DIGITS * DIGIT_W;
    localparam int COUNT_W = $clog2(DIGITS + 1);
    localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
    localparam int TIMER_W = $clog2(LOCK_CYCLES);

    localparam logic [COUNT_W-1:0] COUNT_FULL = COUNT_W'(DIGITS);
    localparam logic [FAIL_W-1:0]  FAIL_LIMIT = FAIL_W'(MAX_FAIL);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(LOCK_CYCLES - 1);

    logic dig_p, ent_p;

    entry_state_t        state_q, state_d;
    logic [CW-1:0]       entry_q, entry_d;
    logic [CW-1:0]       code_q,  code_d;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic [FAIL_W-1:0]   fail_q,  fail_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                match_q, match_d;

    btn_sync_edge u_dig_sync (
        .clk   (clk),
        .RESET (RESET),
        .raw   (DIGIT_BTN),
        .pulse (dig_p)
    );

    btn_sync_edge u_ent_sync (
        .clk   (clk),
        .RESET (RESET),
        .raw   (ENTER_BTN),
        .pulse (ent_p)
    );

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            entry_q <= '0;
            code_q  <= DEFAULT_CODE;
            count_q <= '0;
            fail_q  <= '0;
            timer_q <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            code_q  <= code_d;
            count_q <= count_d;
            fail_q  <= fail_d;
            timer_q <= timer_d;
            match_q <= match_d;
        end
    end

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        code_d  = code_q;
        count_d = count_q;
        fail_d  = fail_q;
        timer_d = timer_q;

        case (state_q)
            IDLE: begin
                // Enter wins over a digit arriving in the same cycle.
                if (ent_p) begin
                    if (PROG) begin
                        if (count_q == COUNT_FULL) begin
                            code_d = entry_q;
                        end
                        entry_d = '0;
                        count_d = '0;
                    end else begin
                        state_d = PRESENT;
                    end
                end else if (dig_p) begin
                    entry_d = {entry_q[CW-DIGIT_W-1:0], DIGIT_IN};
                    if (count_q != COUNT_FULL) begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            PRESENT: begin
                entry_d = '0;
                count_d = '0;
                if (match_q) begin
                    fail_d  = '0;
                    state_d = IDLE;
                end else begin
                    fail_d = fail_q + 1'b1;
                    if (fail_d == FAIL_LIMIT) begin
                        state_d = LOCKOUT;
                        timer_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            LOCKOUT: begin
                if (timer_q == TIMER_LAST) begin
                    state_d = IDLE;
                    fail_d  = '0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Entry is held through PRESENT, so MATCH keeps the submitted result there.
        match_d = (count_d == COUNT_FULL) && (entry_d == code_d);
    end

    assign MATCH      = match_q;
    assign ENTER      = (state_q == PRESENT);
    assign LOCKED_OUT = (state_q == LOCKOUT);
    assign COUNT      = count_q;

endmodule

// File: tb/tb_code_entry.sv
module tb_code_entry;

    localparam int          DIGITS       = 4;
    localparam int          MAX_FAIL     = 3;
    localparam int          LOCK_CYCLES  = 1000;
    localparam logic [15:0] DEFAULT_CODE = 16'h1234;

    logic       clk = 1'b0;
    logic       RESET;
    logic [3:0] DIGIT_IN;
    logic       DIGIT_BTN;
    logic       ENTER_BTN;
    logic       PROG;
    logic       MATCH;
    logic       ENTER;
    logic [2:0] COUNT;
    logic       LOCKED_OUT;

    code_entry dut (
        .clk        (clk),
        .RESET      (RESET),
        .DIGIT_IN   (DIGIT_IN),
        .DIGIT_BTN  (DIGIT_BTN),
        .ENTER_BTN  (ENTER_BTN),
        .PROG       (PROG),
        .MATCH      (MATCH),
        .ENTER      (ENTER),
        .COUNT      (COUNT),
        .LOCKED_OUT (LOCKED_OUT)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: buffer as a digit queue, oldest first.
    int          m_q[$];
    logic [15:0] m_code;
    int          m_fails;
    bit          m_locked;

    function automatic logic [15:0] m_pack();
        logic [15:0] v = '0;
        foreach (m_q[i]) v = {v[11:0], 4'(m_q[i])};
        return v;
    endfunction

    function automatic bit m_match();
        return (m_q.size() == DIGITS) && (m_pack() == m_code);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_code   = DEFAULT_CODE;
        m_fails  = 0;
        m_locked = 0;
    endtask

    // Length of the most recent LOCKED_OUT run, in cycles.
    int lk_run  = 0;
    int lk_last = 0;
    always @(negedge clk) begin
        if (LOCKED_OUT === 1'b1) lk_run++;
        else begin
            if (lk_run != 0) lk_last = lk_run;
            lk_run = 0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic press(input bit dig, input bit ent, input logic [3:0] d, input int hold);
        int          cnt_old, cnt_s2, cnt_s3, first_ent, n_ent, exp_s3;
        bit          exp_enter, exp_m, was_locked;
        logic        m_at_ent;
        cnt_old    = m_q.size();
        was_locked = m_locked;
        exp_enter  = 0;
        exp_m      = 0;
        first_ent  = -1;
        n_ent      = 0;
        m_at_ent   = 1'b0;
        cnt_s2     = 0;
        cnt_s3     = 0;
        if (!m_locked) begin
            if (ent) begin
                if (PROG) begin
                    if (m_q.size() == DIGITS) m_code = m_pack();
                    m_q.delete();
                end else begin
                    exp_enter = 1;
                    exp_m     = m_match();
                    m_q.delete();
                    if (exp_m) m_fails = 0;
                    else begin
                        m_fails++;
                        if (m_fails == MAX_FAIL) begin
                            m_locked = 1;
                            m_fails  = 0;
                        end
                    end
                end
            end else if (dig) begin
                m_q.push_back(int'(d));
                if (m_q.size() > DIGITS) void'(m_q.pop_front());
            end
        end
        exp_s3 = exp_enter ? cnt_old : m_q.size();

        if (dig) DIGIT_IN = d;
        DIGIT_BTN = dig;
        ENTER_BTN = ent;
        for (int i = 1; i <= hold + 4; i++) begin
            tick();
            if (i == 2) cnt_s2 = COUNT;
            if (i == 3) cnt_s3 = COUNT;
            if (ENTER === 1'b1) begin
                n_ent++;
                if (first_ent < 0) begin
                    first_ent = i;
                    m_at_ent  = MATCH;
                end
            end
            if (i == hold) begin
                DIGIT_BTN = 1'b0;
                ENTER_BTN = 1'b0;
            end
        end

        if (dig && !ent && !was_locked) check("count_before_latency", cnt_s2, cnt_old);
        check("count_at_latency", cnt_s3, exp_s3);
        check("enter_pulses", n_ent, exp_enter);
        if (exp_enter) begin
            check("enter_latency", first_ent, 3);
            check("enter_match", m_at_ent, exp_m);
        end
        check("count", COUNT, m_q.size());
        check("match", MATCH, m_match());
        check("locked_out", LOCKED_OUT, m_locked);
    endtask

    task automatic type_code(input logic [31:0] v, input int n);
        logic [31:0] t;
        t = v;
        for (int i = n - 1; i >= 0; i--) press(1'b1, 1'b0, t[i*4 +: 4], $urandom_range(3, 8));
    endtask

    task automatic enter_press(input int hold);
        press(1'b0, 1'b1, 4'd0, hold);
    endtask

    task automatic wait_unlock();
        int n = 0;
        while (LOCKED_OUT === 1'b1 && n < LOCK_CYCLES + 10) begin
            tick();
            n++;
        end
        check("unlock_timeout", LOCKED_OUT, 0);
        check("lockout_len", lk_last, LOCK_CYCLES);
        m_locked = 0;
    endtask

    task automatic async_reset_check(input string tag);
        #2;
        RESET = 1'b1;
        #1;
        check({tag, "_match"},  MATCH, 0);
        check({tag, "_enter"},  ENTER, 0);
        check({tag, "_count"},  COUNT, 0);
        check({tag, "_locked"}, LOCKED_OUT, 0);
        DIGIT_BTN = 1'b0;
        ENTER_BTN = 1'b0;
        PROG      = 1'b0;
        tick();
        tick();
        RESET = 1'b0;
        model_reset();
        tick();
        tick();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET     = 1'b1;
        DIGIT_IN  = 4'd0;
        DIGIT_BTN = 1'b0;
        ENTER_BTN = 1'b0;
        PROG      = 1'b0;
        model_reset();
        #1;
        check("reset_match",  MATCH, 0);
        check("reset_enter",  ENTER, 0);
        check("reset_count",  COUNT, 0);
        check("reset_locked", LOCKED_OUT, 0);
        tick();
        tick();
        RESET = 1'b0;
        tick();

        // Correct code
        type_code(32'h1234, 4);
        enter_press(5);

        // Short code fails, buffer cleared before next attempt
        type_code(32'h123, 3);
        enter_press(4);
        type_code(32'h1234, 4);
        enter_press(3);

        // Overflow drops oldest; long enter hold gives one pulse
        type_code(32'h91234, 5);
        enter_press(20);

        // Lockout, buttons ignored, then recovery
        for (int k = 0; k < MAX_FAIL; k++) begin
            type_code(32'h5555, 4);
            enter_press(4);
        end
        type_code(32'h1234, 4);
        enter_press(4);
        wait_unlock();
        type_code(32'h1234, 4);
        enter_press(4);

        // Programming a new code, partial program ignored, reset restores default
        PROG = 1'b1;
        type_code(32'h5678, 4);
        enter_press(4);
        PROG = 1'b0;
        type_code(32'h1234, 4);
        enter_press(4);
        type_code(32'h5678, 4);
        enter_press(4);
        PROG = 1'b1;
        type_code(32'h12, 2);
        enter_press(4);
        PROG = 1'b0;
        type_code(32'h5678, 4);
        async_reset_check("rst_full_buf");
        type_code(32'h1234, 4);
        enter_press(4);

        // Reset mid-entry and mid-lockout
        type_code(32'h12, 2);
        async_reset_check("rst_mid_entry");
        for (int k = 0; k < MAX_FAIL; k++) begin
            type_code(32'h9999, 4);
            enter_press(4);
        end
        for (int k = 0; k < 50; k++) tick();
        async_reset_check("rst_mid_lock");

        // Simultaneous digit and enter: enter wins
        type_code(32'h123, 3);
        press(1'b1, 1'b1, 4'd4, 5);

        // Randomised attempts
        for (int it = 0; it < 80; it++) begin
            int          kind;
            logic [15:0] wrong;
            kind  = $urandom_range(0, 9);
            wrong = 16'($urandom);
            if (kind == 0) begin
                PROG = 1'b1;
                type_code({16'h0, wrong}, $urandom_range(3, 4));
                enter_press($urandom_range(3, 10));
                PROG = 1'b0;
            end else begin
                case (kind)
                    1, 2, 3, 4: type_code({16'h0, m_code}, 4);
                    5:          type_code({12'h0, 4'($urandom), m_code}, 5);
                    6:          type_code({16'h0, wrong}, $urandom_range(1, 3));
                    default:    type_code({16'h0, wrong}, 4);
                endcase
                if ($urandom_range(0, 4) == 0)
                    press(1'b1, 1'b1, 4'($urandom), $urandom_range(3, 10));
                else
                    enter_press($urandom_range(3, 20));
            end
            if (m_locked) begin
                int extra;
                extra = $urandom_range(0, 3);
                for (int j = 0; j < extra; j++)
                    press($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                          4'($urandom), $urandom_range(3, 6));
                wait_unlock();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
